// File: rtl/mc_ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer with trap, flush, stall and hart interleaving.
// Define SM_PERF_CNT_EN to build the cycle/instret performance counters; otherwise those ports read zero.
module mc_ctrl_sequencer #(
    parameter int NUM_HARTS   = 1,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 200,
    parameter int HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_done_i,
    input  logic [6:0]           opcode_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [NUM_HARTS-1:0] hart_en_i,
    output logic [2:0]           now_state_o,
    output logic [2:0]           now_state_d1_o,
    output logic [2:0]           next_state_o,
    output logic [HART_W-1:0]    hart_id_o,
    output logic [TIMEOUT_W-1:0] state_cycles_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic                 retire_o,
    output logic [31:0]          cycle_cnt_o,
    output logic [31:0]          instret_cnt_o
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;
    localparam logic [2:0] S_IDLE      = 3'd6;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

    logic [2:0]           now_state_q, now_state_d1_q, next_state_d;
    logic [HART_W-1:0]    hart_id_q, hart_id_d;
    logic [TIMEOUT_W-1:0] state_cycles_q;
    logic                 trap_q, trap_d;
    logic [1:0]           trap_cause_q, trap_cause_d;
    logic                 retire_q, retire_d;

    logic                 anyHartEn, isTimeout, advance, completes;
    logic [2:0]           fetchOrIdle;
    logic [1:0]           newCause;
    logic [HART_W-1:0]    lowestHart, rotHart, lowIdx, rotIdx;

    // Lowest enabled hart for leaving IDLE; next enabled hart after the current one for every other FETCH entry.
    always_comb begin
        lowestHart = '0;
        lowIdx     = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            lowIdx = HART_W'(i);
            if (hart_en_i[lowIdx]) lowestHart = lowIdx;
        end
        rotHart = hart_id_q;
        rotIdx  = '0;
        for (int k = NUM_HARTS; k >= 1; k--) begin
            rotIdx = HART_W'((int'(hart_id_q) + k) % NUM_HARTS);
            if (hart_en_i[rotIdx]) rotHart = rotIdx;
        end
    end

    always_comb begin
        anyHartEn    = |hart_en_i;
        isTimeout    = ((now_state_q == S_FETCH) || (now_state_q == S_MEMORY)) &&
                       (state_cycles_q == TO_LAST) && !step_done_i && !stall_i;
        fetchOrIdle  = anyHartEn ? S_FETCH : S_IDLE;
        next_state_d = now_state_q;
        advance      = 1'b0;
        completes    = 1'b0;
        newCause     = CAUSE_NONE;
        if (now_state_q == S_IDLE) begin
            if (!stall_i && anyHartEn) begin
                next_state_d = S_FETCH;
                advance      = 1'b1;
            end
        end else if (flush_i) begin
            next_state_d = fetchOrIdle;
            advance      = 1'b1;
        end else if (!stall_i) begin
            if (isTimeout) begin
                next_state_d = S_TRAP;
                newCause     = CAUSE_TIMEOUT;
                advance      = 1'b1;
            end else if (step_done_i) begin
                advance = 1'b1;
                case (now_state_q)
                    S_FETCH:   next_state_d = S_DECODE;
                    S_DECODE:  next_state_d = S_EXECUTE;
                    S_EXECUTE: begin
                        case (opcode_i)
                            OP_LOAD, OP_STORE: next_state_d = S_MEMORY;
                            OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                                next_state_d = S_WRITEBACK;
                            OP_BRANCH, OP_FENCE, OP_SYSTEM: begin
                                next_state_d = fetchOrIdle;
                                completes    = 1'b1;
                            end
                            default: begin
                                next_state_d = S_TRAP;
                                newCause     = CAUSE_ILLEGAL;
                            end
                        endcase
                    end
                    S_MEMORY: begin
                        if (opcode_i == OP_STORE) begin
                            next_state_d = fetchOrIdle;
                            completes    = 1'b1;
                        end else begin
                            next_state_d = S_WRITEBACK;
                        end
                    end
                    S_WRITEBACK: begin
                        next_state_d = fetchOrIdle;
                        completes    = 1'b1;
                    end
                    S_TRAP:  next_state_d = fetchOrIdle;
                    default: next_state_d = S_IDLE;
                endcase
            end
        end
    end

    // Pulses and the trap cause are registered so they line up with the state they describe.
    always_comb begin
        retire_d     = completes && (next_state_d == S_FETCH);
        trap_d       = advance && (next_state_d == S_TRAP);
        trap_cause_d = trap_cause_q;
        if (advance) begin
            if (next_state_d == S_TRAP)      trap_cause_d = newCause;
            else if (now_state_q == S_TRAP)  trap_cause_d = CAUSE_NONE;
        end
        hart_id_d = hart_id_q;
        if (advance && (next_state_d == S_FETCH)) begin
            hart_id_d = (now_state_q == S_IDLE) ? lowestHart : rotHart;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_state_q    <= S_IDLE;
            now_state_d1_q <= S_IDLE;
            hart_id_q      <= '0;
            state_cycles_q <= '0;
            trap_q         <= 1'b0;
            trap_cause_q   <= CAUSE_NONE;
            retire_q       <= 1'b0;
        end else begin
            now_state_q    <= next_state_d;
            now_state_d1_q <= now_state_q;
            hart_id_q      <= hart_id_d;
            trap_q         <= trap_d;
            trap_cause_q   <= trap_cause_d;
            retire_q       <= retire_d;
            if (advance) begin
                state_cycles_q <= '0;
            end else if (!stall_i && (state_cycles_q != '1)) begin
                state_cycles_q <= state_cycles_q + TIMEOUT_W'(1);
            end
        end
    end

`ifdef SM_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_q + 32'd1;
            instret_cnt_q <= instret_cnt_q + {31'd0, retire_q};
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`else
    assign cycle_cnt_o   = 32'd0;
    assign instret_cnt_o = 32'd0;
`endif

    assign now_state_o    = now_state_q;
    assign now_state_d1_o = now_state_d1_q;
    assign next_state_o   = next_state_d;
    assign hart_id_o      = hart_id_q;
    assign state_cycles_o = state_cycles_q;
    assign trap_o         = trap_q;
    assign trap_cause_o   = trap_cause_q;
    assign retire_o       = retire_q;

endmodule
